// File: rtl/uop_bench_driver.sv
// LFSR stimulus generator and MISR response compactor for the uop benchmark array.
// Optional build macro: UOP_BENCH_SHAMT_SWEEP_EN (shamt_o sweeps with vec_cnt_o during RUN).
module uop_bench_driver #(
    parameter int           W     = 64,
    parameter int           SHW   = $clog2(W),
    parameter logic [W-1:0] POLY  = 64'hD800_0000_0000_0000,
    parameter logic [W-1:0] SEED  = 64'h0000_0000_0000_0001,
    parameter int           N_VEC = 1024,
    parameter int           LAT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic [W-1:0]               src_val_o,
    output logic [SHW-1:0]             shamt_o,
    input  logic [W-1:0]               result_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [W-1:0]               signature_o,
    output logic [$clog2(N_VEC+1)-1:0] vec_cnt_o
);

    localparam int           VCW      = $clog2(N_VEC + 1);
    localparam int           DCW      = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     src_q, src_d;
    logic [W-1:0]     misr_q, misr_d;
    logic [VCW-1:0]   vc_q, vc_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             issue_valid;
    logic             cap_en;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & POLY)};
    endfunction

    function automatic logic [W-1:0] misr_next(input logic [W-1:0] m, input logic [W-1:0] r);
        return {m[W-2:0], ^(m & POLY)} ^ r;
    endfunction

    assign issue_valid = (state_q == S_RUN);

    // Issue-valid travels alongside the vector through the array so captures line up with responses.
    generate
        if (LAT == 0) begin : g_no_pipe
            assign cap_en = issue_valid;
        end else begin : g_pipe
            logic [LAT-1:0] vpipe_q;
            always_ff @(posedge clk) begin
                if (rst) vpipe_q <= '0;
                else     vpipe_q <= (vpipe_q << 1) | LAT'(issue_valid);
            end
            assign cap_en = vpipe_q[LAT-1];
        end
    endgenerate

    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        misr_d  = misr_q;
        vc_d    = vc_q;
        drain_d = drain_q;
        if (cap_en) misr_d = misr_next(misr_q, result_i);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    src_d   = SEED_EFF;
                    misr_d  = '0;
                    vc_d    = '0;
                end
            end
            S_RUN: begin
                vc_d = vc_q + 1'b1;
                if (vc_q == VCW'(N_VEC - 1)) begin
                    src_d   = '0;
                    drain_d = '0;
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    src_d = lfsr_next(src_q);
                end
            end
            S_DRAIN: begin
                if (drain_q == DCW'(LAT - 1)) state_d = S_DONE;
                else                          drain_d = drain_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            misr_q  <= '0;
            vc_q    <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            misr_q  <= misr_d;
            vc_q    <= vc_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        shamt_o = '0;
        if (state_q == S_RUN) begin
`ifdef UOP_BENCH_SHAMT_SWEEP_EN
            shamt_o = SHW'(vc_q);
`else
            shamt_o = src_q[W-1 -: SHW];
`endif
        end
    end

    assign src_val_o   = src_q;
    assign signature_o = misr_q;
    assign vec_cnt_o   = vc_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_uop_bench_driver.sv
// Self-checking bench for uop_bench_driver: directed tables, hand sequences and a randomized model.
module tb_uop_bench_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst, start, busy, done;
    logic [3:0][7:0]  res, src, sig, vc;
    logic [3:0][2:0]  sh;
    logic [2:0]       vc0, vc1;
    logic [1:0]       vc2;
    logic [3:0]       vc3;

    assign vc[0] = 8'(vc0);
    assign vc[1] = 8'(vc1);
    assign vc[2] = 8'(vc2);
    assign vc[3] = 8'(vc3);

    uop_bench_driver #(.W(8), .POLY(8'hB8), .SEED(8'h01), .N_VEC(5), .LAT(0)) u_a (
        .clk(clk), .rst(rst[0]), .start_i(start[0]), .src_val_o(src[0]), .shamt_o(sh[0]),
        .result_i(res[0]), .busy_o(busy[0]), .done_o(done[0]), .signature_o(sig[0]), .vec_cnt_o(vc0));
    uop_bench_driver #(.W(8), .POLY(8'hB8), .SEED(8'h01), .N_VEC(4), .LAT(2)) u_b (
        .clk(clk), .rst(rst[1]), .start_i(start[1]), .src_val_o(src[1]), .shamt_o(sh[1]),
        .result_i(res[1]), .busy_o(busy[1]), .done_o(done[1]), .signature_o(sig[1]), .vec_cnt_o(vc1));
    uop_bench_driver #(.W(8), .POLY(8'hB8), .SEED(8'h00), .N_VEC(2), .LAT(0)) u_c (
        .clk(clk), .rst(rst[2]), .start_i(start[2]), .src_val_o(src[2]), .shamt_o(sh[2]),
        .result_i(res[2]), .busy_o(busy[2]), .done_o(done[2]), .signature_o(sig[2]), .vec_cnt_o(vc2));
    uop_bench_driver #(.W(8), .POLY(8'hB8), .SEED(8'h01), .N_VEC(10), .LAT(3)) u_r (
        .clk(clk), .rst(rst[3]), .start_i(start[3]), .src_val_o(src[3]), .shamt_o(sh[3]),
        .result_i(res[3]), .busy_o(busy[3]), .done_o(done[3]), .signature_o(sig[3]), .vec_cnt_o(vc3));

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic       start;
        logic [7:0] src;
        logic       busy;
        logic       done;
        logic [7:0] vc;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [7:0] lfsr8(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic logic [7:0] misr8(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], ^(m & 8'hB8)} ^ r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int i, input string tag);
        check($sformatf("%s_src%0d", tag, i),  src[i], 8'h00);
        check($sformatf("%s_sh%0d", tag, i),   8'(sh[i]), 8'h00);
        check($sformatf("%s_busy%0d", tag, i), 8'(busy[i]), 8'h00);
        check($sformatf("%s_done%0d", tag, i), 8'(done[i]), 8'h00);
        check($sformatf("%s_vc%0d", tag, i),   vc[i], 8'h00);
        check($sformatf("%s_sig%0d", tag, i),  sig[i], 8'h00);
    endtask

    // N_VEC=4, LAT=2, result 0xFF, with an extra start pulse in cycle 2 that must be ignored.
    task automatic run_b(input string tag);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check({tag, "_sig_clr"}, sig[1], 8'h00);
        check({tag, "_vc0"}, vc[1], 8'h00);
        for (int c = 0; c < 9; c++) begin
            check($sformatf("%s_busy_c%0d", tag, c), 8'(busy[1]), 8'(c < 6));
            check($sformatf("%s_done_c%0d", tag, c), 8'(done[1]), 8'(c >= 6));
            start[1] = (c == 2);
            tick();
        end
        start[1] = 1'b0;
        check({tag, "_sig"}, sig[1], 8'h05);
        check({tag, "_vc"},  vc[1], 8'h04);
        check({tag, "_src"}, src[1], 8'h00);
    endtask

    // Reference model for N_VEC=10, LAT=3 derived from the cycle timing rules.
    task automatic run_rand(input int run);
        localparam int N = 10;
        localparam int L = 3;
        logic [7:0] mv, msig, r;
        logic [2:0] exp_sh;
        mv   = 8'h01;
        msig = 8'h00;
        start[3] = 1'b1;
        res[3]   = 8'($urandom);
        tick();
        for (int c = 0; c < N + L + 3; c++) begin
            if (c < N) begin
`ifdef UOP_BENCH_SHAMT_SWEEP_EN
                exp_sh = 3'(c % 8);
`else
                exp_sh = mv[7:5];
`endif
            end else begin
                exp_sh = 3'd0;
            end
            check($sformatf("r%0d_src_c%0d", run, c),  src[3], (c < N) ? mv : 8'h00);
            check($sformatf("r%0d_sh_c%0d", run, c),   8'(sh[3]), 8'(exp_sh));
            check($sformatf("r%0d_busy_c%0d", run, c), 8'(busy[3]), 8'(c < N + L));
            check($sformatf("r%0d_done_c%0d", run, c), 8'(done[3]), 8'(c >= N + L));
            check($sformatf("r%0d_vc_c%0d", run, c),   vc[3], 8'((c < N) ? c : N));
            check($sformatf("r%0d_sig_c%0d", run, c),  sig[3], msig);
            if (c < N) mv = lfsr8(mv);
            start[3] = (c <= N + L - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            r        = 8'($urandom);
            res[3]   = r;
            if (c >= L && c <= N - 1 + L) msig = misr8(msig, r);
            tick();
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 8'h02, 1'b1, 1'b0, 8'd1};
        tbl[2] = '{1'b0, 8'h04, 1'b1, 1'b0, 8'd2};
        tbl[3] = '{1'b0, 8'h08, 1'b1, 1'b0, 8'd3};
        tbl[4] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'd4};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd5};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd5};

        rst   = '1;
        start = '0;
        res   = '0;
        repeat (3) tick();
        rst = '0;

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) check_zero(i, $sformatf("idle%0d", k));
            tick();
        end

        for (int k = 0; k < 7; k++) begin
            start[0] = tbl[k].start;
            tick();
            check($sformatf("t_src_%0d", k),  src[0], tbl[k].src);
            check($sformatf("t_busy_%0d", k), 8'(busy[0]), 8'(tbl[k].busy));
            check($sformatf("t_done_%0d", k), 8'(done[0]), 8'(tbl[k].done));
            check($sformatf("t_vc_%0d", k),   vc[0], tbl[k].vc);
        end
        start[0] = 1'b0;

        res[1] = 8'hFF;
        run_b("b1");
        run_b("b2");

        res[2]   = 8'h3C;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        check("z_src0", src[2], 8'h01);
        tick();
        check("z_src1", src[2], 8'h02);
        tick();
        check("z_done", 8'(done[2]), 8'h01);
        check("z_vc",   vc[2], 8'h02);
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        check("z2_src0", src[2], 8'h01);
        tick();
        check("z2_busy1", 8'(busy[2]), 8'h01);
        rst[2] = 1'b1;
        tick();
        check_zero(2, "rst");
        rst[2] = 1'b0;
        tick();
        check_zero(2, "post_rst");

        for (int run = 0; run < 4; run++) run_rand(run);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
